// File: rtl/halut_pkg.sv
// halut_pkg: shared sizing for the HALUT decoder slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Holds the table geometry (K prototypes x C codebooks), the signed LUT entry
// width, and the derived address/accumulator widths used by the decoder.
package halut_pkg;

  localparam int unsigned K             = 16;
  localparam int unsigned C             = 32;
  localparam int unsigned DataTypeWidth = 16;

  localparam int unsigned CAddrWidth    = $clog2(C);
  localparam int unsigned TreeDepth     = $clog2(K);
  localparam int unsigned LutAddrWidth  = $clog2(C * K);
  // C signed entries summed in DataTypeWidth+log2(C) bits cannot overflow.
  localparam int unsigned AccWidth      = DataTypeWidth + $clog2(C);

endpackage

// File: rtl/halut_lut_mem.sv
// halut_lut_mem: 1-write / 1-read RAM with registered read data.
// Latency: rdata_o valid 1 cycle after re_i; a same-cycle write to the read address returns the old word.
// Backpressure: none, a read and a write are accepted every cycle.
// Ports:
//   clk_i           clock (contents and read register are not reset)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i    read request; rdata_o holds its value while re_i is low
//   rdata_o         registered read data
module halut_lut_mem #(
  parameter int unsigned Depth     = 512,
  parameter int unsigned Width     = 16,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Both the write and the read sample the array in the same clock edge with
  // non-blocking updates, so a colliding read sees the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/halut_decoder.sv
// halut_decoder: accumulates signed LUT[c][k] entries over C accepted codes and emits one row result.
// Latency: last code accepted in cycle t -> valid_o high in cycle t+2 for one cycle; full rate, no bubbles between rows.
// Backpressure: none; valid_i low stalls the row, decoder_i low flushes in-flight work.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   we_i, waddr_i, wdata_i         LUT load port (address c*K+k), works regardless of decoder_i
//   decoder_i                      decode enable; low = idle/flush
//   c_addr_i, k_addr_i, valid_i    code stream from the encoder
//   result_o, valid_o              signed row result and its one-cycle strobe
//   row_cnt_o                      rows completed since decoding started (wraps)
module halut_decoder
  import halut_pkg::*;
#(
  parameter int unsigned K             = halut_pkg::K,
  parameter int unsigned C             = halut_pkg::C,
  parameter int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
  localparam int unsigned CAddrWidth   = $clog2(C),
  localparam int unsigned TreeDepth    = $clog2(K),
  localparam int unsigned LutAddrWidth = $clog2(C * K),
  localparam int unsigned AccWidth     = DataTypeWidth + $clog2(C)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [LutAddrWidth-1:0]  waddr_i,
  input  logic [DataTypeWidth-1:0] wdata_i,
  input  logic                     we_i,
  input  logic                     decoder_i,
  input  logic [CAddrWidth-1:0]    c_addr_i,
  input  logic [TreeDepth-1:0]     k_addr_i,
  input  logic                     valid_i,
  output logic [AccWidth-1:0]      result_o,
  output logic                     valid_o,
  output logic [15:0]              row_cnt_o
);

  localparam int unsigned LutDepth = C * K;
  localparam int unsigned ExtWidth = AccWidth - DataTypeWidth;

  logic                     accept;
  logic                     cnt_at_last;
  logic [CAddrWidth-1:0]    elem_cnt_q;
  logic                     s1_vld_q;
  logic                     s1_last_q;
  logic [DataTypeWidth-1:0] lut_rdata;
  logic [AccWidth-1:0]      rdata_ext;
  logic [AccWidth-1:0]      acc_q;
  logic [AccWidth-1:0]      acc_sum;

  assign accept      = decoder_i & valid_i;
  assign cnt_at_last = (elem_cnt_q == CAddrWidth'(C - 1));

  // {c, k} concatenation equals c*K + k because K is a power of two.
  halut_lut_mem #(
    .Depth (LutDepth),
    .Width (DataTypeWidth)
  ) u_lut_mem (
    .clk_i   (clk_i),
    .we_i    (we_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .re_i    (accept),
    .raddr_i ({c_addr_i, k_addr_i}),
    .rdata_o (lut_rdata)
  );

  // Two's complement add of the sign-extended entry; the width makes overflow impossible.
  assign rdata_ext = {{ExtWidth{lut_rdata[DataTypeWidth-1]}}, lut_rdata};
  assign acc_sum   = acc_q + rdata_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_cnt_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      result_o   <= '0;
      valid_o    <= 1'b0;
      row_cnt_o  <= '0;
    end else if (!decoder_i) begin
      // Flush: drop in-flight entries, restart the row; result_o keeps its last value.
      elem_cnt_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      valid_o    <= 1'b0;
      row_cnt_o  <= '0;
    end else begin
      valid_o <= 1'b0;

      // Row completion is by count: the encoder interleaves codebooks, so c_addr order is arbitrary.
      if (accept) begin
        elem_cnt_q <= cnt_at_last ? '0 : elem_cnt_q + 1'b1;
      end

      // S0 -> S1: the LUT read is in flight alongside these flags.
      s1_vld_q  <= accept;
      s1_last_q <= accept & cnt_at_last;

      // S1: accumulate; on the last entry publish and restart so the next row
      // can enter S1 in the very next cycle.
      if (s1_vld_q) begin
        if (s1_last_q) begin
          result_o  <= acc_sum;
          valid_o   <= 1'b1;
          acc_q     <= '0;
          row_cnt_o <= row_cnt_o + 16'd1;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_halut_decoder.sv
// tb_halut_decoder: directed self-checking bench for halut_decoder.
// Latency: n/a.
// Backpressure: n/a.
module tb_halut_decoder;
  import halut_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [LutAddrWidth-1:0]  waddr_i;
  logic [DataTypeWidth-1:0] wdata_i;
  logic                     we_i;
  logic                     decoder_i;
  logic [CAddrWidth-1:0]    c_addr_i;
  logic [TreeDepth-1:0]     k_addr_i;
  logic                     valid_i;
  logic [AccWidth-1:0]      result_o;
  logic                     valid_o;
  logic [15:0]              row_cnt_o;

  halut_decoder dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .we_i      (we_i),
    .decoder_i (decoder_i),
    .c_addr_i  (c_addr_i),
    .k_addr_i  (k_addr_i),
    .valid_i   (valid_i),
    .result_o  (result_o),
    .valid_o   (valid_o),
    .row_cnt_o (row_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // number of rising edges seen so far
  int last_edge;     // edge at which the most recent code was sampled
  int code_c [32];
  int code_k [32];
  int coll_idx  = -1;
  int coll_data = 0;
  int res_q [$];
  int cyc_q [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Capture every result strobe on the falling edge, with the edge count it followed.
  always @(negedge clk_i) begin
    if (valid_o) begin
      res_q.push_back(int'($signed(result_o)));
      cyc_q.push_back(cyc);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d expected < 100000", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_lut(input int addr, input int data);
    waddr_i = LutAddrWidth'(addr);
    wdata_i = DataTypeWidth'(data);
    we_i    = 1'b1;
    tick();
    we_i    = 1'b0;
  endtask

  task automatic fill_lut(input int mode, input int value);
    // mode 0: entry = its own address (= c*16+k); mode 1: constant value
    for (int a = 0; a < C * K; a++) write_lut(a, (mode == 0) ? a : value);
  endtask

  task automatic set_ordered(input int r);
    for (int i = 0; i < 32; i++) begin
      code_c[i] = i;
      code_k[i] = (i + r) % 16;
    end
  endtask

  task automatic set_interleaved();
    // order 0,8,16,24,1,9,17,25,...
    for (int i = 0; i < 32; i++) begin
      code_c[i] = (i % 4) * 8 + i / 4;
      code_k[i] = code_c[i] % 16;
    end
  endtask

  task automatic send_codes(input int n, input int max_gap);
    int gap;
    for (int i = 0; i < n; i++) begin
      c_addr_i = CAddrWidth'(code_c[i]);
      k_addr_i = TreeDepth'(code_k[i]);
      valid_i  = 1'b1;
      if (i == coll_idx) begin
        waddr_i = LutAddrWidth'(code_c[i] * 16 + code_k[i]);
        wdata_i = DataTypeWidth'(coll_data);
        we_i    = 1'b1;
      end
      tick();
      we_i      = 1'b0;
      last_edge = cyc;
      if (max_gap > 0) begin
        gap = $urandom_range(max_gap, 0);
        if (gap > 0) begin
          valid_i = 1'b0;
          repeat (gap) tick();
        end
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n);
    int b = 0;
    while (res_q.size() < n && b < 100) begin
      tick();
      b++;
    end
    repeat (3) tick();
    check({tag, "_pulses"}, res_q.size(), n);
  endtask

  task automatic clear_q();
    res_q.delete();
    cyc_q.delete();
  endtask

  initial begin
    rst_ni    = 1'b0;
    waddr_i   = '0;
    wdata_i   = '0;
    we_i      = 1'b0;
    decoder_i = 1'b0;
    c_addr_i  = '0;
    k_addr_i  = '0;
    valid_i   = 1'b0;
    repeat (3) tick();
    check("rst_result", int'(result_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_rowcnt", int'(row_cnt_o), 0);
    rst_ni = 1'b1;
    tick();

    // Basic row: LUT[c][k] = c*16+k, codes c=0..31 with k=c%16.
    fill_lut(0, 0);
    decoder_i = 1'b1;
    tick();
    clear_q();
    set_ordered(0);
    send_codes(32, 0);
    wait_pulses("basic", 1);
    if (res_q.size() >= 1) begin
      check("basic_result", res_q[0], 8176);
      // sampled at edge N -> result registered at edge N+1 (cycle t+2 visible)
      check("basic_latency", cyc_q[0] - last_edge, 1);
    end
    check("basic_rowcnt", int'(row_cnt_o), 1);
    check("basic_valid_low", int'(valid_o), 0);

    // Collision: rewrite LUT[5*16+3] while it is being read; k=(c+14)%16 hits k=3 at c=5.
    clear_q();
    set_ordered(14);
    coll_idx  = 5;
    coll_data = 1000;
    send_codes(32, 0);
    coll_idx  = -1;
    wait_pulses("coll", 1);
    if (res_q.size() >= 1) check("coll_old", res_q[0], 8176);
    clear_q();
    send_codes(32, 0);
    wait_pulses("coll_new", 1);
    if (res_q.size() >= 1) check("coll_new", res_q[0], 8176 - 83 + 1000);
    check("coll_rowcnt", int'(row_cnt_o), 3);

    // Three rows back-to-back, no idle cycle between them.
    clear_q();
    set_ordered(0);
    send_codes(32, 0);
    set_ordered(7);
    send_codes(32, 0);
    set_ordered(14);
    send_codes(32, 0);
    wait_pulses("b2b", 3);
    if (res_q.size() >= 3) begin
      check("b2b_res0", res_q[0], 8176);
      check("b2b_res1", res_q[1], 8176);
      check("b2b_res2", res_q[2], 9093);
      check("b2b_gap01", cyc_q[1] - cyc_q[0], 32);
      check("b2b_gap12", cyc_q[2] - cyc_q[1], 32);
      check("b2b_latency", cyc_q[2] - last_edge, 1);
    end
    check("b2b_rowcnt", int'(row_cnt_o), 6);

    // Interleaved codebook order with random idle gaps.
    clear_q();
    set_interleaved();
    send_codes(32, 3);
    wait_pulses("gap", 1);
    if (res_q.size() >= 1) check("gap_result", res_q[0], 8176);
    check("gap_rowcnt", int'(row_cnt_o), 7);

    // Drop decoder_i after 10 codes, then a full row.
    clear_q();
    set_ordered(0);
    send_codes(10, 0);
    decoder_i = 1'b0;
    repeat (4) tick();
    check("drop_pulses", res_q.size(), 0);
    check("drop_rowcnt", int'(row_cnt_o), 0);
    check("drop_result_hold", int'($signed(result_o)), 8176);
    decoder_i = 1'b1;
    tick();
    send_codes(32, 0);
    wait_pulses("redo", 1);
    if (res_q.size() >= 1) check("redo_result", res_q[0], 8176);
    check("redo_rowcnt", int'(row_cnt_o), 1);

    // Extreme values.
    fill_lut(1, -32768);
    clear_q();
    send_codes(32, 0);
    wait_pulses("min", 1);
    if (res_q.size() >= 1) check("min_result", res_q[0], -1048576);
    fill_lut(1, 32767);
    clear_q();
    send_codes(32, 0);
    wait_pulses("max", 1);
    if (res_q.size() >= 1) check("max_result", res_q[0], 1048544);
    check("max_rowcnt", int'(row_cnt_o), 3);

    // Asynchronous reset in the middle of a row, between clock edges.
    clear_q();
    send_codes(10, 0);
    rst_ni = 1'b0;
    #1;
    check("arst_rowcnt", int'(row_cnt_o), 0);
    check("arst_result", int'(result_o), 0);
    check("arst_valid", int'(valid_o), 0);
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    send_codes(32, 0);
    wait_pulses("arst_row", 1);
    if (res_q.size() >= 1) check("arst_row_result", res_q[0], 1048544);
    check("arst_row_rowcnt", int'(row_cnt_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/halut_decoder.md
Name: halut_decoder

Overview:
Consumer end of the encoder's (c_addr, k_addr, valid) stream. For each accepted code it reads the signed LUT entry LUT[c][k] from a local table and accumulates it. After C codes it emits one accumulated dot-product result. The block sits directly downstream of the 4-unit encoder wrapper; its LUT is loaded through a write port before decoding.

Parameters:
K, halut_pkg::K (16), prototypes per codebook
C, halut_pkg::C (32), codebooks per output row
DataTypeWidth, halut_pkg::DataTypeWidth (16), signed LUT entry width
CAddrWidth, $clog2(C), derived, do not override
TreeDepth, $clog2(K), derived, do not override
LutAddrWidth, $clog2(C*K), derived, do not override
AccWidth, DataTypeWidth+$clog2(C), derived, accumulator/result width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
waddr_i  in  LutAddrWidth  LUT write address = c*K + k
wdata_i  in  DataTypeWidth  signed LUT write data
we_i  in  1  LUT write enable
decoder_i  in  1  decode enable; low = idle/flush
c_addr_i  in  CAddrWidth  codebook index from encoder
k_addr_i  in  TreeDepth  prototype index from encoder
valid_i  in  1  code valid
result_o  out  AccWidth  signed accumulated row result
valid_o  out  1  one-cycle pulse, result_o valid
row_cnt_o  out  16  completed rows since decode start, wraps at 2^16

Behaviour:
- Reset: result_o=0, valid_o=0, row_cnt_o=0; element counter=0; accumulator=0; all pipeline valids=0.
- LUT: C*K x DataTypeWidth, one write port and one synchronous read port with 1-cycle read latency. The same-cycle read/write to the same address returns the OLD data. Writes are accepted regardless of decoder_i. LUT contents are not reset.
- Accept: a code is accepted when decoder_i && valid_i. The read address is {c_addr_i, k_addr_i}, i.e. c*K+k.
- Pipeline, with acceptance at cycle t:
  - S0 (t): LUT read issued; the last flag is registered when elem_cnt==C-1.
  - S1 (t+1): read data is sign-extended to AccWidth and added to the accumulator.
  - If last: result_o <= acc+data and valid_o=1 at t+2. The accumulator clears to 0 in the same cycle, and row_cnt_o increments.
- Latency: the last code accepted at t gives valid_o high at t+2 for exactly 1 cycle. Back-to-back rows are supported at full rate (1 code/cycle) with no bubble. The first code of the next row may be accepted at t+1.
- Element counter: 0..C-1. It increments per accepted code and wraps to 0 after C-1. Completion is by count, not by c_addr value, because the encoder interleaves codebooks across its units. c_addr is used only for addressing.
- Overflow: none possible by AccWidth sizing. Arithmetic is two's complement.
- Gaps: valid_i low while decoder_i is high causes a stall. Counter and accumulator hold, and in-flight pipeline stages still complete.
- decoder_i falls mid-row: in-flight S0/S1 data is dropped, the counter and accumulator clear next cycle, and no valid_o is produced. result_o holds its last value and row_cnt_o resets to 0.
- decoder_i rising: decoding starts with counter=0 and acc=0.
- Async reset mid-row: all state returns to reset values immediately.

Decomposition:
- halut_pkg: K, C, DataTypeWidth; add AccWidth = DataTypeWidth+$clog2(C) as a package constant.
- Sub-module halut_lut_mem: parameterized 1W/1R synchronous-read RAM (Depth, Width), read-old-on-collision, reusable by the encoder threshold memory.
- halut_decoder contains the counter, pipeline registers and accumulator.

Test Plan:
- Load LUT[c][k]=c*16+k; stream c=0..31 with k=c%16, one per cycle -> one valid_o pulse 2 cycles after the last code, result_o = sum(c*16+c%16) = 8176, row_cnt_o=1.
- Load all LUT=-32768; stream 32 codes -> result_o = -1048576 (no overflow in AccWidth=21); repeat with all 32767 -> 1048544.
- Stream 3 rows back-to-back with no gaps -> valid_o pulses spaced exactly 32 cycles apart, row_cnt_o=3, and each result matches the model.
- Row with valid_i gaps (random 0-3 idle cycles) and interleaved c order 0,8,16,24,1,9,... -> same result as the ordered stream.
- Drop decoder_i after 10 codes, then re-enable and send a full row -> no pulse for the partial row; next result equals the full-row sum only; row_cnt_o=1.
- Write LUT[5*16+3] in the same cycle it is read -> old value accumulated; the next row uses the new value.
